// File: rtl/aurora_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one Aurora TX AXI-stream port among NUM_SRC sources.
// Data path is a zero-latency passthrough from the granted source; grant, frame count and error are registered.
module aurora_tx_arbiter #(
  parameter int NUM_SRC   = 3,
  parameter int GNT_W     = 2,
  parameter int MAX_BEATS = 64
) (
  input  logic                  io_clk,
  input  logic                  reset,
  input  logic [NUM_SRC*32-1:0] src_tdata,
  input  logic [NUM_SRC-1:0]    src_tvalid,
  input  logic [NUM_SRC-1:0]    src_tlast,
  output logic [NUM_SRC-1:0]    src_tready,
  input  logic                  channel_up,
  output logic [31:0]           tx_data,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  output logic [3:0]            tx_tkeep,
  input  logic                  tx_tready,
  output logic                  busy,
  output logic [GNT_W-1:0]      grant_id,
  output logic [15:0]           frame_cnt,
  output logic                  err_long
);

  localparam int NPAD = 2 ** GNT_W;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [GNT_W-1:0]  last_q, last_d;
  logic [15:0]       beat_q, beat_d;
  logic [15:0]       frame_q, frame_d;
  logic              err_q, err_d;

  logic [31:0]       data_pad [NPAD];
  logic [NPAD-1:0]   valid_pad;
  logic [NPAD-1:0]   last_pad;
  logic [NPAD-1:0]   rdy_pad;
  logic [GNT_W-1:0]  cand;
  logic [GNT_W-1:0]  pick;
  logic              pick_vld;
  logic              g_valid;
  logic              g_last;
  logic              force_last;
  logic              xfer_fire;

  // Pad the source vectors to a power of two so the grant index never selects out of range.
  for (genvar i = 0; i < NPAD; i++) begin : g_pad
    if (i < NUM_SRC) begin : g_src
      assign data_pad[i]  = src_tdata[32*i +: 32];
      assign valid_pad[i] = src_tvalid[i];
      assign last_pad[i]  = src_tlast[i];
    end else begin : g_none
      assign data_pad[i]  = '0;
      assign valid_pad[i] = 1'b0;
      assign last_pad[i]  = 1'b0;
    end
  end

  always_comb begin
    cand     = last_q;
    pick     = last_q;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (cand == GNT_W'(NUM_SRC - 1)) ? '0 : cand + GNT_W'(1);
      if (!pick_vld && valid_pad[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign g_valid    = valid_pad[grant_q];
  assign g_last     = last_pad[grant_q];
  assign force_last = (beat_q == 16'(MAX_BEATS - 1));
  assign xfer_fire  = (state_q == XFER) && g_valid && tx_tready;

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GNT_W'(NUM_SRC - 1);
      beat_q  <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (channel_up && pick_vld) begin
          state_d = XFER;
          grant_d = pick;
          last_d  = pick;
          beat_d  = '0;
        end
      end
      XFER: begin
        // channel_up is ignored here so an in-flight frame always completes.
        if (xfer_fire) begin
          beat_d = beat_q + 16'd1;
          if (g_last || force_last) begin
            state_d = IDLE;
            frame_d = frame_q + 16'd1;
            if (!g_last) err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_pad   = '0;
    tx_data   = '0;
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
    tx_tkeep  = 4'h0;
    if (state_q == XFER) begin
      rdy_pad[grant_q] = tx_tready;
      tx_data          = data_pad[grant_q];
      tx_tvalid        = g_valid;
      tx_tlast         = g_last || force_last;
      tx_tkeep         = g_valid ? 4'hF : 4'h0;
    end
    src_tready = rdy_pad[NUM_SRC-1:0];
  end

  assign busy      = (state_q == XFER);
  assign grant_id  = grant_q;
  assign frame_cnt = frame_q;
  assign err_long  = err_q;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter: AXI source queues, a frame-level reference model
// compared every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_aurora_tx_arbiter;

  localparam int NS   = 3;
  localparam int GW   = 2;
  localparam int MAXB = 4;

  logic             io_clk;
  logic             reset;
  logic [NS*32-1:0] src_tdata;
  logic [NS-1:0]    src_tvalid;
  logic [NS-1:0]    src_tlast;
  logic [NS-1:0]    src_tready;
  logic             channel_up;
  logic [31:0]      tx_data;
  logic             tx_tvalid;
  logic             tx_tlast;
  logic [3:0]       tx_tkeep;
  logic             tx_tready;
  logic             busy;
  logic [GW-1:0]    grant_id;
  logic [15:0]      frame_cnt;
  logic             err_long;

  aurora_tx_arbiter #(.NUM_SRC(NS), .GNT_W(GW), .MAX_BEATS(MAXB)) dut (
    .io_clk(io_clk), .reset(reset),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tlast(src_tlast), .src_tready(src_tready),
    .channel_up(channel_up),
    .tx_data(tx_data), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tkeep(tx_tkeep), .tx_tready(tx_tready),
    .busy(busy), .grant_id(grant_id), .frame_cnt(frame_cnt), .err_long(err_long)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source side: one queue of {last, data} beats per source.
  logic [32:0] srcq [NS][$];
  logic [NS-1:0] vld;
  bit gap_en;

  int n_pass, n_total, cyc;

  // Reference model state (frame level).
  bit m_busy;
  int m_g, m_last, m_beats, m_frames;
  bit m_err;

  int log_data[$];
  int log_last[$];
  int log_cyc[$];
  int gnt_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
    gnt_log.delete();
  endtask

  task automatic push_beat(input int s, input logic [31:0] d, input bit last);
    srcq[s].push_back({last, d});
  endtask

  function automatic bit pending();
    bit p;
    p = m_busy;
    for (int s = 0; s < NS; s++) if (srcq[s].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive_inputs();
    logic [32:0] h;
    for (int s = 0; s < NS; s++) begin
      if (srcq[s].size() > 0) begin
        h = srcq[s][0];
        src_tdata[32*s +: 32] = h[31:0];
        src_tlast[s]          = h[32];
        src_tvalid[s]         = vld[s];
      end else begin
        src_tdata[32*s +: 32] = '0;
        src_tlast[s]          = 1'b0;
        src_tvalid[s]         = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model, return just after posedge.
  task automatic step();
    logic [31:0] e_data;
    logic        e_v, e_l;
    logic [3:0]  e_k;
    logic [2:0]  e_r;
    bit          fire, found;
    int          idx;
    cyc++;
    drive_inputs();
    @(negedge io_clk);
    e_data = '0; e_v = 1'b0; e_l = 1'b0; e_k = 4'h0; e_r = '0;
    if (m_busy) begin
      e_data = src_tdata[32*m_g +: 32];
      e_v    = src_tvalid[m_g];
      e_l    = src_tlast[m_g] || (m_beats == MAXB - 1);
      e_k    = e_v ? 4'hF : 4'h0;
      e_r    = tx_tready ? 3'(1 << m_g) : 3'b000;
    end
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_g);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("err_long", err_long, m_err);
    chk("src_tready", src_tready, e_r);
    chk("tx_tvalid", tx_tvalid, e_v);
    chk("tx_tlast", tx_tlast, e_l);
    chk("tx_tkeep", tx_tkeep, e_k);
    chk("tx_data", tx_data, e_data);

    fire = m_busy && e_v && tx_tready;
    if (fire) begin
      void'(srcq[m_g].pop_front());
      vld[m_g] = 1'b0;
    end
    if (reset) begin
      m_busy = 0; m_g = 0; m_last = NS - 1; m_beats = 0; m_frames = 0; m_err = 0;
    end else if (!m_busy) begin
      if (channel_up && (src_tvalid != '0)) begin
        found = 0;
        for (int i = 1; i <= NS; i++) begin
          idx = (m_last + i) % NS;
          if (!found && src_tvalid[idx]) begin
            found = 1;
            m_g   = idx;
          end
        end
        gnt_log.push_back(m_g);
        m_last  = m_g;
        m_beats = 0;
        m_busy  = 1;
      end
    end else if (fire) begin
      log_data.push_back(int'(e_data));
      log_last.push_back(int'(e_l));
      log_cyc.push_back(cyc);
      m_beats++;
      if (e_l) begin
        m_frames = (m_frames + 1) % 65536;
        if (!src_tlast[m_g]) m_err = 1;
        m_busy = 0;
      end
    end
    for (int s = 0; s < NS; s++)
      if (!vld[s]) vld[s] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge io_clk);
    #1;
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      step();
      n++;
    end
    chk(name, n < max, 1'b1);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    int t_req, n, len, s;
    n_pass = 0; n_total = 0; cyc = 0;
    m_busy = 0; m_g = 0; m_last = NS - 1; m_beats = 0; m_frames = 0; m_err = 0;
    vld = '1; gap_en = 0;
    reset = 1'b1; channel_up = 1'b1; tx_tready = 1'b1;
    src_tdata = '0; src_tvalid = '0; src_tlast = '0;
    @(posedge io_clk);
    #1;
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err_long, 1'b0);
    clear_logs();

    // Single 3-beat frame from source 0.
    push_beat(0, 32'h11, 0); push_beat(0, 32'h22, 0); push_beat(0, 32'h33, 1);
    t_req = cyc + 1;
    drain("t1_drain", 20);
    chk("t1_nbeats", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("t1_d0", log_data[0], 32'h11);
      chk("t1_d1", log_data[1], 32'h22);
      chk("t1_d2", log_data[2], 32'h33);
      chk("t1_last", {log_last[0][0], log_last[1][0], log_last[2][0]}, 3'b001);
      chk("t1_first_cyc", log_cyc[0], t_req + 1);
      chk("t1_last_cyc", log_cyc[2], t_req + 3);
    end
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_grant", grant_id, 0);

    // Round robin, all sources requesting with 2-beat frames.
    reset_pulse();
    for (int f = 0; f < 2; f++)
      for (int q = 0; q < NS; q++) begin
        push_beat(q, 32'h100 * q + 32'h10 * f + 1, 0);
        push_beat(q, 32'h100 * q + 32'h10 * f + 2, 1);
      end
    drain("t2_drain", 60);
    chk("t2_ngrants", gnt_log.size(), 6);
    if (gnt_log.size() == 6)
      for (int k = 0; k < 6; k++) chk("t2_order", gnt_log[k], k % 3);
    chk("t2_frame_cnt", frame_cnt, 6);
    if (log_cyc.size() == 12)
      for (int f = 0; f < 5; f++) chk("t2_bubble", log_cyc[2*f+2] - log_cyc[2*f+1], 2);

    // Backpressure on a 4-beat source 1 frame.
    reset_pulse();
    for (int k = 0; k < 4; k++) push_beat(1, 32'hA1 + k, k == 3);
    n = 0;
    while (pending() && n < 40) begin
      tx_tready = (n % 2 == 0);
      step();
      n++;
    end
    chk("t3_bound", n < 40, 1'b1);
    tx_tready = 1'b1;
    chk("t3_nbeats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t3_data", log_data[k], 32'hA1 + k);
      chk("t3_span", log_cyc[3] - log_cyc[0], 6);
    end

    // Over-length: 6 beats with MAX_BEATS=4.
    reset_pulse();
    for (int k = 0; k < 6; k++) push_beat(2, 32'hC1 + k, k == 5);
    drain("t4_drain", 30);
    chk("t4_nbeats", log_data.size(), 6);
    if (log_last.size() == 6) begin
      chk("t4_last4", log_last[3], 1);
      chk("t4_last5", log_last[4], 0);
      chk("t4_last6", log_last[5], 1);
      chk("t4_d5", log_data[4], 32'hC5);
      chk("t4_bubble", log_cyc[4] - log_cyc[3], 2);
    end
    chk("t4_err", err_long, 1'b1);
    chk("t4_frame_cnt", frame_cnt, 2);
    chk("t4_ngrants", gnt_log.size(), 2);

    // Reset on beat 2 of a 5-beat frame, with a second source waiting.
    clear_logs();
    for (int k = 0; k < 5; k++) push_beat(1, 32'hD1 + k, k == 4);
    push_beat(2, 32'hE1, 0); push_beat(2, 32'hE2, 1);
    n = 0;
    while (log_data.size() < 1 && n < 10) begin
      step();
      n++;
    end
    chk("t5_bound", n < 10, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_err", err_long, 1'b0);
    chk("t5_grant", grant_id, 0);
    chk("t5_tvalid", tx_tvalid, 1'b0);
    chk("t5_tready", src_tready, 3'b000);
    chk("t5_tkeep", tx_tkeep, 4'h0);
    clear_logs();
    drain("t5_drain", 30);
    chk("t5_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    chk("t5_nbeats", log_data.size(), 5);
    if (log_data.size() == 5) begin
      chk("t5_d0", log_data[0], 32'hD3);
      chk("t5_d3", log_data[3], 32'hE1);
    end

    // channel_up gating.
    reset_pulse();
    channel_up = 1'b0;
    for (int k = 0; k < 3; k++) push_beat(0, 32'hF1 + k, k == 2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_grant", busy, 1'b0);
    end
    channel_up = 1'b1;
    step();
    chk("t6_grant_busy", busy, 1'b1);
    step();
    channel_up = 1'b0;
    drain("t6_drain", 20);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_nbeats", log_data.size(), 3);
    channel_up = 1'b1;

    // Random traffic with valid gaps, backpressure, channel drops and rare resets.
    gap_en = 1;
    for (int c = 0; c < 3000; c++) begin
      tx_tready  = ($urandom_range(0, 3) != 0);
      channel_up = ($urandom_range(0, 19) != 0);
      reset      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, NS - 1);
        if (srcq[s].size() < 12) begin
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) push_beat(s, $urandom, k == len - 1);
        end
      end
      step();
    end
    reset = 1'b0; channel_up = 1'b1; tx_tready = 1'b1;
    drain("rand_drain", 2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
# aurora_tx_arbiter

Frame-atomic round-robin arbiter that shares the single Aurora TX AXI-stream port between several packet sources. Examples of sources are the programmed-I/O packet generator and stub/track-fit output streams. It sits between the sources and the Aurora core TX interface in the ST I/O block, on the same clock. It also provides grant status, a frame counter and an over-length error flag that the readback mux can read.

## Interface
Parameters:
- NUM_SRC, 3: number of requesting sources (2..4).
- GNT_W, 2: width of grant index; NUM_SRC ≤ 2^GNT_W.
- MAX_BEATS, 64: maximum beats per frame before forced termination (2..65535).

Ports:
- io_clk, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-high.
- src_tdata, in, NUM_SRC*32: source i occupies bits [32i+31:32i].
- src_tvalid, in, NUM_SRC: per-source valid.
- src_tlast, in, NUM_SRC: per-source last beat of frame.
- src_tready, out, NUM_SRC: per-source ready.
- channel_up, in, 1: Aurora channel status; no new grant is issued while low.
- tx_data, out, 32: to Aurora TX.
- tx_tvalid, out, 1: to Aurora TX.
- tx_tlast, out, 1: to Aurora TX.
- tx_tkeep, out, 4: to Aurora TX.
- tx_tready, in, 1: from Aurora TX.
- busy, out, 1: a frame is granted (state XFER).
- grant_id, out, GNT_W: index of the current or most recent grant.
- frame_cnt, out, 16: completed frames, wrapping.
- err_long, out, 1: sticky; set when a frame was truncated at MAX_BEATS.

## Operation
- States: IDLE, XFER.
- IDLE:
  - If channel_up=1 and any src_tvalid=1, select the first requesting source scanning from (last+1) mod NUM_SRC upward with wrap.
  - Register the selection into grant_id and last, clear beat_cnt, and go to XFER.
  - All src_tready=0, tx_tvalid=0.
- XFER, combinational passthrough from source g=grant_id:
  - tx_data=src_tdata[g]
  - tx_tvalid=src_tvalid[g]
  - src_tready[g]=tx_tready; all other src_tready=0
  - tx_tkeep=4'hF when tx_tvalid, else 4'h0
- A beat transfers when tx_tvalid & tx_tready. Each transfer increments beat_cnt (16 bit).
- tx_tlast = src_tlast[g] | (beat_cnt == MAX_BEATS-1).
- On a transfer with tx_tlast=1:
  - frame_cnt += 1 (wraps 0xFFFF→0), return to IDLE.
  - If the forced term caused the last (src_tlast[g]=0), set err_long.
  - Any remaining beats of that source frame are arbitrated later as a new frame.
- channel_up falling during XFER does not abort the frame; the grant is held until tlast transfers.
- Sources not granted are never acknowledged, so their data is held by AXI rules.
- A single requester is re-granted every frame. Starvation bound is (NUM_SRC-1) frames.

## Timing
- Reset values: state IDLE, busy 0, grant_id 0, last = NUM_SRC-1 (so the first grant prefers source 0), frame_cnt 0, err_long 0, beat_cnt 0, all src_tready 0, tx_tvalid 0, tx_tlast 0, tx_tkeep 0, tx_data 0.
- The grant decision takes 1 cycle. The first beat can transfer in the cycle after a request is seen in IDLE.
- Data path latency is 0 cycles (combinational) during XFER.
- There is exactly one IDLE bubble cycle between consecutive frames.
- busy equals (state==XFER) and is registered.
- frame_cnt and err_long update on the edge ending the tlast beat.
- Reset asserted mid-frame: return to the reset values on the next edge. The frame is abandoned with no tlast emitted; the Aurora core handles recovery.
- The grant scan evaluates src_tvalid and channel_up only in IDLE. Changes to other sources' valids during XFER have no effect.

## Test plan
- Single frame: src0 sends a 3-beat frame, 0x11,0x22,0x33 with tlast on the third beat; tx_tready=1, channel_up=1. Expect tx_data 0x11/0x22/0x33 on consecutive cycles starting 1 cycle after the request, tx_tlast only on 0x33, tx_tkeep=F, frame_cnt=1, grant_id=0.
- Round robin: all 3 sources request continuously with 2-beat frames. Expect grant order 0,1,2,0,1,2 with one idle cycle between frames, and frame_cnt=6 after 6 frames.
- Backpressure: tx_tready toggles 1,0,1,0 during a 4-beat src1 frame. Expect src_tready[1] to mirror tx_tready, tx_data held stable while stalled, all 4 beats delivered in order, and other src_tready=0.
- Over-length: MAX_BEATS=4, src2 sends 6 beats with tlast on beat 6. Expect forced tx_tlast on beat 4, err_long=1, then beats 5–6 sent as a new frame with natural tlast, frame_cnt +2.
- channel_up gating: channel_up=0 with src0 valid. Expect no grant, busy=0. Raise channel_up: grant is issued next cycle. Drop channel_up mid-frame: the frame still completes.
- Reset mid-frame: assert reset on beat 2 of 5. The next cycle shows all outputs at reset values; after release, the first grant goes to the lowest requesting index.
